// File: rtl/pow5_share_arbiter.sv
// pow5_share_arbiter
//
// Lets n_req requesters share one pipelined, flow-controlled pow_5 unit.
// Operands go upstream through a round-robin arbiter. An in-order tag FIFO
// records which requester issued each accepted operand, and each result
// coming out of the pipeline is steered back to that requester. Both
// directions are purely combinational, so the block adds no cycles of latency.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req_vld/req_rdy  per-requester operand handshake
//   req_data         packed operands, requester i at [i*width +: width]
//   rsp_vld/rsp_rdy  per-requester result handshake
//   rsp_data         result, broadcast to all requesters, qualified by rsp_vld
//   pipe_up_*        operand handshake towards the pow_5 pipeline
//   pipe_down_*      result handshake from the pow_5 pipeline
//   in_flight        tag FIFO occupancy
//   err              sticky protocol error
module pow5_share_arbiter #(
    parameter int n_req         = 4,
    parameter int width         = 12,
    parameter int max_in_flight = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [n_req-1:0]                 req_vld,
    output logic [n_req-1:0]                 req_rdy,
    input  logic [n_req*width-1:0]           req_data,
    output logic [n_req-1:0]                 rsp_vld,
    input  logic [n_req-1:0]                 rsp_rdy,
    output logic [width-1:0]                 rsp_data,
    output logic                             pipe_up_vld,
    input  logic                             pipe_up_rdy,
    output logic [width-1:0]                 pipe_up_data,
    input  logic                             pipe_down_vld,
    output logic                             pipe_down_rdy,
    input  logic [width-1:0]                 pipe_down_data,
    output logic [$clog2(max_in_flight):0]   in_flight,
    output logic                             err
);

    localparam int id_w  = $clog2(n_req);
    localparam int ptr_w = $clog2(max_in_flight);

    logic [id_w-1:0]  rr_ptr_q, rr_ptr_d;
    logic [id_w-1:0]  locked_id_q, locked_id_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic [id_w-1:0]  tag_mem_q [max_in_flight];
    logic [id_w-1:0]  tag_mem_d [max_in_flight];
    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [ptr_w:0]   count_q, count_d;

    logic [id_w-1:0]  grant;
    logic [id_w-1:0]  head;
    int               scan_idx;
    logic             full, empty;
    logic             up_vld, up_fire, down_fire;

    assign full  = (count_q == (ptr_w+1)'(max_in_flight));
    assign empty = (count_q == '0);
    assign head  = tag_mem_q[rd_ptr_q];

    // Grant selection. While a grant is locked it is held so the pipeline
    // sees stable data. Otherwise the scan runs from the highest offset down
    // so the last hit, the one nearest rr_ptr, wins without needing a break.
    always_comb begin
        grant    = rr_ptr_q;
        scan_idx = 0;
        if (lock_q) begin
            grant = locked_id_q;
        end else begin
            for (int k = n_req - 1; k >= 0; k--) begin
                scan_idx = int'(rr_ptr_q) + k;
                if (scan_idx >= n_req) begin
                    scan_idx = scan_idx - n_req;
                end
                if (req_vld[scan_idx]) begin
                    grant = id_w'(scan_idx);
                end
            end
        end
    end

    assign up_vld    = req_vld[grant] & ~full;
    assign up_fire   = up_vld & pipe_up_rdy;
    assign down_fire = pipe_down_vld & pipe_down_rdy;

    // Handshake outputs. They are gated by rst_n so that they drop the instant
    // reset is asserted, not at the next clock edge.
    always_comb begin
        req_rdy       = '0;
        rsp_vld       = '0;
        pipe_up_vld   = up_vld & rst_n;
        pipe_up_data  = req_data[int'(grant)*width +: width];
        pipe_down_rdy = rst_n & ~empty & rsp_rdy[head];
        rsp_data      = pipe_down_data;
        if (rst_n && up_fire) begin
            req_rdy[grant] = 1'b1;
        end
        for (int i = 0; i < n_req; i++) begin
            rsp_vld[i] = rst_n & pipe_down_vld & ~empty & (head == id_w'(i));
        end
    end

    // Next-state logic for the arbiter, the tag FIFO and the error flag.
    // A push needs up_fire, and up_fire already includes ~full, so a pop in
    // the same cycle never frees room for a push. A locked requester that
    // drops valid is only a violation when it was not accepted, so that check
    // sits after both handshake branches.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        locked_id_d = locked_id_q;
        lock_d      = lock_q;
        err_d       = err_q;
        tag_mem_d   = tag_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (up_fire) begin
            tag_mem_d[wr_ptr_q] = grant;
            wr_ptr_d            = wr_ptr_q + 1'b1;
            rr_ptr_d            = (grant == id_w'(n_req - 1)) ? '0 : grant + 1'b1;
            lock_d              = 1'b0;
        end else if (up_vld) begin
            lock_d      = 1'b1;
            locked_id_d = grant;
        end else if (lock_q && !req_vld[locked_id_q]) begin
            err_d  = 1'b1;
            lock_d = 1'b0;
        end

        if (down_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (pipe_down_vld && empty) begin
            err_d = 1'b1;
        end

        case ({up_fire, down_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            locked_id_q <= '0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < max_in_flight; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            locked_id_q <= locked_id_d;
            lock_q      <= lock_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tag_mem_q   <= tag_mem_d;
        end
    end

    assign in_flight = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pow5_share_arbiter.sv
// Testbench for pow5_share_arbiter. The bench plays the requesters and the
// pow_5 pipeline, and it checks the arbiter against its own model of issue
// order and result routing.
module tb_pow5_share_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 12;
   localparam int MIF  = 8;
   localparam int CW   = 4;
   localparam int LAT  = 3;
   localparam int RAND_CYCLES = 10000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_vld, req_rdy, rsp_vld, rsp_rdy;
   logic [NREQ*W-1:0] req_data;
   logic [W-1:0]      rsp_data, pipe_up_data, pipe_down_data;
   logic              pipe_up_vld, pipe_up_rdy, pipe_down_vld, pipe_down_rdy, err;
   logic [CW-1:0]     in_flight;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [NREQ-1:0] vld;
      logic            upRdy;
      logic [NREQ-1:0] expRdy;
      logic            expUpVld;
      int              expData;
   } vec_t;

   vec_t vecs[7];

   // Random-phase model state
   bit  hasOp[NREQ];
   int  op[NREQ];
   int  waits[NREQ];
   int  expQ[NREQ][$];
   int  tagQ[$];
   int  pipeQ[$];
   int  pipeTs[$];
   int  mNext;
   bit  mLocked;
   int  mLid;

   always #5 clk = ~clk;

   pow5_share_arbiter #(.n_req(NREQ), .width(W), .max_in_flight(MIF)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_data(req_data),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
      .pipe_up_vld(pipe_up_vld), .pipe_up_rdy(pipe_up_rdy), .pipe_up_data(pipe_up_data),
      .pipe_down_vld(pipe_down_vld), .pipe_down_rdy(pipe_down_rdy),
      .pipe_down_data(pipe_down_data),
      .in_flight(in_flight), .err(err)
   );

   // Reference result of the shared unit
   function automatic int pow5(input int x);
      return x * x * x * x * x;
   endfunction

   // Compares one observed value with the bench's expectation
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drives all non-data DUT inputs at once
   task automatic applyStimulus(input logic [NREQ-1:0] vld, input logic upRdy,
                                input logic [NREQ-1:0] rRdy, input logic dnVld,
                                input int dnData);
      req_vld        = vld;
      pipe_up_rdy    = upRdy;
      rsp_rdy        = rRdy;
      pipe_down_vld  = dnVld;
      pipe_down_data = W'(dnData);
   endtask

   // Advances to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requester i presents operand 2+i (2,3,4,5)
   task automatic setFixedData();
      for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = W'(2 + i);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus('0, 1'b0, '0, 1'b0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int g, h;
      int expRsp, expDnRdy, expUp, expReq;
      bit full, idle;
      int cyc;

      vecs[0] = '{4'b0000, 1'b1, 4'b0000, 1'b0, -1};
      vecs[1] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 3};
      vecs[2] = '{4'b1100, 1'b1, 4'b0100, 1'b1, 4};
      vecs[3] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 5};
      vecs[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2};
      vecs[5] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 3};
      vecs[6] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2};

      // Outputs are forced low while reset is held, even with busy inputs
      setFixedData();
      applyStimulus(4'b1111, 1'b1, 4'b1111, 1'b1, 7);
      #2;
      checkOutput("rst_req_rdy", req_rdy, 0);
      checkOutput("rst_rsp_vld", rsp_vld, 0);
      checkOutput("rst_up_vld", pipe_up_vld, 0);
      checkOutput("rst_dn_rdy", pipe_down_rdy, 0);
      doReset();
      @(negedge clk);
      checkOutput("rst_in_flight", in_flight, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_up_vld_idle", pipe_up_vld, 0);

      // Single-cycle arbitration vectors, each from a fresh reset (rr_ptr=0)
      for (int v = 0; v < 7; v++) begin
         doReset();
         setFixedData();
         applyStimulus(vecs[v].vld, vecs[v].upRdy, '0, 1'b0, 0);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_req_rdy", v), req_rdy, vecs[v].expRdy);
         checkOutput($sformatf("vec%0d_up_vld", v), pipe_up_vld, vecs[v].expUpVld);
         if (vecs[v].expData >= 0)
            checkOutput($sformatf("vec%0d_up_data", v), pipe_up_data, vecs[v].expData);
      end

      // Single requester round trip: 3 -> 243 routed to requester 1
      doReset();
      setFixedData();
      applyStimulus(4'b0010, 1'b1, 4'b1111, 1'b0, 0);
      @(negedge clk);
      checkOutput("rt_up_data", pipe_up_data, 3);
      checkOutput("rt_req_rdy", req_rdy, 4'b0010);
      tick();
      req_vld = '0;
      @(negedge clk);
      checkOutput("rt_in_flight1", in_flight, 1);
      tick();
      applyStimulus('0, 1'b1, 4'b1111, 1'b1, pow5(3));
      @(negedge clk);
      checkOutput("rt_rsp_vld", rsp_vld, 4'b0010);
      checkOutput("rt_rsp_data", rsp_data, 243);
      checkOutput("rt_dn_rdy", pipe_down_rdy, 1);
      tick();
      pipe_down_vld = 1'b0;
      @(negedge clk);
      checkOutput("rt_in_flight0", in_flight, 0);

      // Stalled grant to requester 2 must stay locked when requester 0 arrives
      doReset();
      setFixedData();
      applyStimulus(4'b0100, 1'b0, '0, 1'b0, 0);
      for (int c = 0; c < 3; c++) begin
         if (c == 1) req_vld = 4'b0101;
         @(negedge clk);
         checkOutput("lock_up_vld", pipe_up_vld, 1);
         checkOutput("lock_up_data", pipe_up_data, 4);
         checkOutput("lock_req_rdy", req_rdy, 0);
         tick();
      end
      pipe_up_rdy = 1'b1;
      @(negedge clk);
      checkOutput("lock_accept", req_rdy, 4'b0100);
      tick();
      req_vld = 4'b0001;
      @(negedge clk);
      checkOutput("lock_next", req_rdy, 4'b0001);
      checkOutput("lock_next_data", pipe_up_data, 2);
      tick();
      req_vld = '0;
      @(negedge clk);
      checkOutput("lock_in_flight", in_flight, 2);
      checkOutput("lock_err", err, 0);

      // Rotation with all requesters valid, saturation at MIF, then in-order drain
      doReset();
      setFixedData();
      applyStimulus(4'b1111, 1'b1, 4'b0000, 1'b0, 0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c < MIF) begin
            checkOutput($sformatf("sat_grant%0d", c), req_rdy, 1 << (c % NREQ));
            checkOutput($sformatf("sat_fill%0d", c), in_flight, c);
         end else begin
            checkOutput("sat_up_vld", pipe_up_vld, 0);
            checkOutput("sat_req_rdy", req_rdy, 0);
            checkOutput("sat_in_flight", in_flight, MIF);
         end
         tick();
      end
      for (int k = 0; k < MIF; k++) begin
         applyStimulus((k == 0) ? 4'b1111 : 4'b0000, 1'b1, 4'b1111, 1'b1, pow5(2 + k % NREQ));
         @(negedge clk);
         checkOutput($sformatf("drain_rsp_vld%0d", k), rsp_vld, 1 << (k % NREQ));
         checkOutput($sformatf("drain_rsp_data%0d", k), rsp_data, pow5(2 + k % NREQ));
         checkOutput($sformatf("drain_in_flight%0d", k), in_flight, MIF - k);
         if (k == 0) checkOutput("full_no_bypass", pipe_up_vld, 0);
         tick();
      end
      pipe_down_vld = 1'b0;
      @(negedge clk);
      checkOutput("drain_empty", in_flight, 0);
      checkOutput("drain_err", err, 0);

      // Randomized traffic against the issue-order / routing model
      doReset();
      for (int i = 0; i < NREQ; i++) begin
         hasOp[i] = 0; op[i] = 0; waits[i] = 0; expQ[i].delete();
      end
      tagQ.delete(); pipeQ.delete(); pipeTs.delete();
      mNext = 0; mLocked = 0; mLid = 0;
      idle = 0;
      for (cyc = 0; cyc < RAND_CYCLES + 400; cyc++) begin
         if (cyc > 0) tick();
         for (int i = 0; i < NREQ; i++) begin
            if (!hasOp[i] && cyc < RAND_CYCLES && $urandom_range(0, 2) != 0) begin
               hasOp[i] = 1;
               op[i] = int'($urandom_range(0, 5));
            end
            req_vld[i] = hasOp[i];
            req_data[i*W +: W] = W'(op[i]);
         end
         rsp_rdy     = NREQ'($urandom_range(0, 15));
         pipe_up_rdy = ($urandom_range(0, 3) != 0);
         if (pipeQ.size() > 0 && cyc >= pipeTs[0]) begin
            pipe_down_vld  = 1'b1;
            pipe_down_data = W'(pow5(pipeQ[0]));
         end else begin
            pipe_down_vld  = 1'b0;
            pipe_down_data = '0;
         end

         @(negedge clk);
         full = (tagQ.size() == MIF);
         g = -1;
         if (mLocked) g = mLid;
         else
            for (int k = NREQ - 1; k >= 0; k--)
               if (hasOp[(mNext + k) % NREQ]) g = (mNext + k) % NREQ;
         expUp  = (g >= 0 && hasOp[g] && !full) ? 1 : 0;
         expReq = (expUp != 0 && pipe_up_rdy) ? (1 << g) : 0;
         checkOutput("rnd_up_vld", pipe_up_vld, expUp);
         checkOutput("rnd_req_rdy", req_rdy, expReq);
         if (expUp != 0) checkOutput("rnd_up_data", pipe_up_data, op[g]);
         checkOutput("rnd_in_flight", in_flight, tagQ.size());

         expRsp = 0; expDnRdy = 0; h = -1;
         if (tagQ.size() > 0) begin
            h = tagQ[0];
            expDnRdy = rsp_rdy[h];
            if (pipe_down_vld) expRsp = 1 << h;
         end
         checkOutput("rnd_rsp_vld", rsp_vld, expRsp);
         checkOutput("rnd_dn_rdy", pipe_down_rdy, expDnRdy);

         if (expRsp != 0 && expDnRdy != 0) begin
            if (expQ[h].size() == 0) checkOutput("rnd_sb_underflow", 1, 0);
            else checkOutput($sformatf("rnd_rsp_data_r%0d", h), rsp_data, expQ[h].pop_front());
            void'(tagQ.pop_front());
            void'(pipeQ.pop_front());
            void'(pipeTs.pop_front());
         end

         if (expReq != 0) begin
            tagQ.push_back(g);
            expQ[g].push_back(pow5(op[g]));
            pipeQ.push_back(op[g]);
            pipeTs.push_back(cyc + LAT);
            for (int j = 0; j < NREQ; j++)
               if (j != g && hasOp[j]) waits[j]++;
            checkOutput($sformatf("rnd_starve_r%0d", g), (waits[g] <= NREQ - 1) ? 1 : 0, 1);
            waits[g] = 0;
            hasOp[g] = 0;
            mNext = (g + 1) % NREQ;
            mLocked = 0;
         end else if (expUp != 0) begin
            mLocked = 1;
            mLid = g;
         end

         idle = (tagQ.size() == 0);
         for (int i = 0; i < NREQ; i++) if (hasOp[i]) idle = 0;
         if (cyc >= RAND_CYCLES && idle) break;
      end
      checkOutput("rnd_drained", idle ? 1 : 0, 1);
      for (int i = 0; i < NREQ; i++)
         checkOutput($sformatf("rnd_leftover_r%0d", i), expQ[i].size(), 0);
      checkOutput("rnd_err", err, 0);

      // Asynchronous reset in the middle of traffic with five results pending
      tick();
      doReset();
      setFixedData();
      applyStimulus(4'b0001, 1'b1, 4'b0000, 1'b0, 0);
      repeat (5) tick();
      req_vld = '0;
      @(negedge clk);
      checkOutput("mid_in_flight5", in_flight, 5);
      @(posedge clk);
      #2;
      applyStimulus(4'b1111, 1'b1, 4'b1111, 1'b1, 9);
      #1;
      checkOutput("mid_pre_up_vld", pipe_up_vld, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_req_rdy", req_rdy, 0);
      checkOutput("mid_rsp_vld", rsp_vld, 0);
      checkOutput("mid_up_vld", pipe_up_vld, 0);
      checkOutput("mid_dn_rdy", pipe_down_rdy, 0);
      checkOutput("mid_in_flight0", in_flight, 0);
      applyStimulus('0, 1'b0, '0, 1'b0, 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("mid_post_in_flight", in_flight, 0);
      checkOutput("mid_post_err", err, 0);
      tick();
      applyStimulus(4'b1111, 1'b1, '0, 1'b0, 0);
      @(negedge clk);
      checkOutput("mid_post_rr_ptr", req_rdy, 4'b0001);

      // Result arriving with no tag pending sets the sticky error
      doReset();
      applyStimulus('0, 1'b0, 4'b1111, 1'b1, 5);
      @(negedge clk);
      checkOutput("err_dn_rdy", pipe_down_rdy, 0);
      checkOutput("err_rsp_vld", rsp_vld, 0);
      checkOutput("err_before", err, 0);
      tick();
      pipe_down_vld = 1'b0;
      @(negedge clk);
      checkOutput("err_set", err, 1);
      repeat (3) tick();
      @(negedge clk);
      checkOutput("err_sticky", err, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pow5_share_arbiter.md
Name: pow5_share_arbiter

Overview:
- Shares one pipelined, flow-controlled pow_5 unit (valid/ready in, valid/ready out, in-order, variable latency under backpressure) between n_req requesters.
- Round-robin arbitration on the upstream side.
- An in-order tag FIFO records which requester issued each accepted operand and routes every result back to that requester.
- Sits between requester logic (keys/counters in board tops) and the pow_5 pipeline; adds zero latency on either path.

Parameters:
- n_req, 4, number of requesters (2..8)
- width, 12, operand/result width, same as the pipeline's width
- max_in_flight, 8, tag FIFO depth; power of 2; must be >= pipeline stage count for full throughput

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- req_vld  in  n_req  per-requester operand valid
- req_rdy  out  n_req  per-requester operand ready
- req_data  in  n_req*width  operands; requester i occupies bits [i*width +: width]
- rsp_vld  out  n_req  per-requester result valid
- rsp_rdy  in  n_req  per-requester result ready
- rsp_data  out  width  result, broadcast to all requesters; qualified by rsp_vld
- pipe_up_vld  out  1  to pipeline input valid
- pipe_up_rdy  in  1  from pipeline input ready
- pipe_up_data  out  width  to pipeline operand
- pipe_down_vld  in  1  from pipeline output valid
- pipe_down_rdy  out  1  to pipeline output ready
- pipe_down_data  in  width  from pipeline result
- in_flight  out  $clog2(max_in_flight)+1  tag FIFO occupancy
- err  out  1  sticky protocol error

Behaviour:
Reset (rst_n low, asynchronous):
- rr_ptr=0, lock=0, FIFO empty, in_flight=0, err=0.
- req_rdy, rsp_vld, pipe_up_vld and pipe_down_rdy are forced 0 while rst_n is low.

Upstream arbitration:
- full = (in_flight == max_in_flight).
- When lock=0, grant = first i with req_vld[i], searching from rr_ptr upward and wrapping.
- When lock=1, grant = locked_id.
- pipe_up_vld = req_vld[grant] & ~full; pipe_up_data = req_data[grant].
- req_rdy[i] = (i == grant) & pipe_up_rdy & ~full & req_vld[i]. All other req_rdy bits are 0.
- Handshake (pipe_up_vld & pipe_up_rdy): push grant into the FIFO, rr_ptr <= (grant+1) mod n_req, lock <= 0.
- pipe_up_vld=1 & pipe_up_rdy=0: lock <= 1, locked_id <= grant. The grant and data stay stable until accepted, even if a higher-priority requester raises req_vld.
- Requesters must hold req_vld/req_data until req_rdy. If a locked requester drops req_vld, set err and clear lock.
- full blocks a push even when a pop happens in the same cycle (no bypass). pipe_up_vld stays 0 while full; lock is unaffected.

Downstream routing:
- head = FIFO head tag.
- rsp_vld[i] = pipe_down_vld & ~empty & (head == i); rsp_data = pipe_down_data.
- pipe_down_rdy = ~empty & rsp_rdy[head].
- Handshake pops the FIFO.
- A stalled rsp_rdy[head] backpressures the whole pipeline. This is intended; there is no reordering.
- pipe_down_vld while the FIFO is empty: set err, keep pipe_down_rdy=0.

Occupancy:
- in_flight changes by +1 on push only, -1 on pop only, and is unchanged on simultaneous push+pop.
- Read/write pointers wrap modulo max_in_flight.

Latency:
- Combinational pass-through both directions, 0 added cycles.
- Throughput is 1 op/cycle when not full and not backpressured.

Test Plan:
- Single requester 1, req_data=3, all ready -> pipe_up_data=3 on the issue cycle. Pipeline returns 243 -> rsp_vld=4'b0010, rsp_data=243, in_flight 1->0.
- Requesters 0..3 hold valid continuously with operands 2,3,4,5 -> grants rotate 0,1,2,3,0,… one per cycle. Results 32,243,1024,3125 return to rsp_vld bits 0,1,2,3 in that order.
- pipe_up_rdy=0 for 3 cycles with requester 2 granted, then requester 0 raises req_vld -> grant stays 2 and pipe_up_data stays constant until accepted. Requester 0 is served next cycle.
- Hold rsp_rdy=0 on all requesters and pipe_down_rdy low -> in_flight saturates at 8, pipe_up_vld=0, req_rdy=0. Release -> drains in order, with no loss or duplication (scoreboard per requester).
- Random req_vld/rsp_rdy over 10k cycles with mixed operands 0..5 -> every requester's results match x^5 in issue order. err stays 0. No requester is starved for more than n_req grants.
- Assert rst_n low mid-traffic with in_flight=5 -> all outputs drop to 0 immediately. After release: in_flight=0, rr_ptr=0, err=0. Forcing pipe_down_vld with an empty FIFO -> err=1 and sticky.
